// File: rtl/firebird7_ijtag_pkg.sv
// Shared IJTAG TDR access types: driver FSM state encoding used by the driver
// and by the benches that monitor it.
package firebird7_ijtag_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CAPTURE = 3'd1,
        SHIFT   = 3'd2,
        UPDATE  = 3'd3,
        DONE    = 3'd4
    } tdr_state_e;

endpackage

// File: rtl/firebird7_in_ijtag_tdr_driver.sv
// IJTAG initiator: one CAPTURE-SHIFT-UPDATE pass into a single downstream TDR
// per request, returning the captured word.
module firebird7_in_ijtag_tdr_driver
    import firebird7_ijtag_pkg::*;
#(
    parameter int TDR_LEN = 2
) (
    input  logic               ijtag_tck,
    input  logic               ijtag_reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [TDR_LEN-1:0] req_wdata,
    output logic               rsp_valid,
    output logic [TDR_LEN-1:0] rsp_rdata,
    output logic               busy,
    output logic               ijtag_sel,
    output logic               ijtag_ce,
    output logic               ijtag_se,
    output logic               ijtag_ue,
    output logic               ijtag_si,
    input  logic               ijtag_so
);

    localparam int CNT_W = $clog2(TDR_LEN + 1);

    tdr_state_e         state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [TDR_LEN-1:0] wdata_sr;
    logic [TDR_LEN-1:0] cap_sr;
    logic               accept;
    logic               shift_last;

    assign accept     = (state == IDLE) && req_valid;
    assign shift_last = (cnt == CNT_W'(TDR_LEN - 1));

    always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
        if (!ijtag_reset) state <= IDLE;
        else              state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = CAPTURE;
            CAPTURE: state_nxt = SHIFT;
            SHIFT:   if (shift_last) state_nxt = UPDATE;
            UPDATE:  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // All target-facing controls decode straight from the state register so
    // ce/se/ue can never overlap and never appear without sel.
    always_comb begin
        req_ready = 1'b0;
        busy      = 1'b1;
        rsp_valid = 1'b0;
        ijtag_sel = 1'b0;
        ijtag_ce  = 1'b0;
        ijtag_se  = 1'b0;
        ijtag_ue  = 1'b0;
        ijtag_si  = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
            end
            CAPTURE: begin
                ijtag_sel = 1'b1;
                ijtag_ce  = 1'b1;
            end
            SHIFT: begin
                ijtag_sel = 1'b1;
                ijtag_se  = 1'b1;
                ijtag_si  = wdata_sr[0];
            end
            UPDATE: begin
                ijtag_sel = 1'b1;
                ijtag_ue  = 1'b1;
            end
            DONE:    rsp_valid = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    // so arrives already retimed on the negedge, so it is sampled on the same
    // posedge that ends the shift cycle; rsp_rdata is only refreshed on the
    // way into DONE so it holds between responses.
    always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
        if (!ijtag_reset) begin
            cnt       <= '0;
            wdata_sr  <= '0;
            cap_sr    <= '0;
            rsp_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (accept) wdata_sr <= req_wdata;
                end
                SHIFT: begin
                    wdata_sr <= wdata_sr >> 1;
                    for (int i = 0; i < TDR_LEN; i++)
                        if (cnt == CNT_W'(i)) cap_sr[i] <= ijtag_so;
                    cnt <= shift_last ? '0 : cnt + 1'b1;
                end
                UPDATE:  rsp_rdata <= cap_sr;
                default: cnt <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_firebird7_in_ijtag_tdr_driver.sv
// Bench: driver + 2-bit EDT TDR model (bit0 = bypass, bit1 = low-power shift
// enable), plus a TDR_LEN=1 driver with a 1-bit TDR model.
module tb_firebird7_in_ijtag_tdr_driver;

    logic ijtag_tck   = 1'b0;
    logic ijtag_reset = 1'b0;
    always #5 ijtag_tck = ~ijtag_tck;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- TDR_LEN = 2 driver and EDT TDR model
    logic       req_valid2 = 1'b0;
    logic [1:0] req_wdata2 = '0;
    logic       req_ready2, rsp_valid2, busy2;
    logic [1:0] rsp_rdata2;
    logic       sel2, ce2, se2, ue2, si2, so2;
    logic [1:0] sr2, upd2;

    firebird7_in_ijtag_tdr_driver #(.TDR_LEN(2)) dut2 (
        .ijtag_tck(ijtag_tck), .ijtag_reset(ijtag_reset),
        .req_valid(req_valid2), .req_ready(req_ready2), .req_wdata(req_wdata2),
        .rsp_valid(rsp_valid2), .rsp_rdata(rsp_rdata2), .busy(busy2),
        .ijtag_sel(sel2), .ijtag_ce(ce2), .ijtag_se(se2), .ijtag_ue(ue2),
        .ijtag_si(si2), .ijtag_so(so2)
    );

    always @(posedge ijtag_tck or negedge ijtag_reset) begin
        if (!ijtag_reset)    sr2 <= '0;
        else if (sel2 & ce2) sr2 <= upd2;
        else if (sel2 & se2) sr2 <= {si2, sr2[1]};
    end
    always @(negedge ijtag_tck or negedge ijtag_reset) begin
        if (!ijtag_reset) begin
            so2  <= 1'b0;
            upd2 <= '0;
        end else begin
            so2 <= sr2[0];
            if (sel2 & ue2) upd2 <= sr2;
        end
    end
    wire edt_bypass             = upd2[0];
    wire edt_low_power_shift_en = upd2[1];

    // ---------------- TDR_LEN = 1 driver and 1-bit TDR model
    logic req_valid1 = 1'b0;
    logic req_wdata1 = 1'b0;
    logic req_ready1, rsp_valid1, busy1, rsp_rdata1;
    logic sel1, ce1, se1, ue1, si1, so1, sr1, upd1;

    firebird7_in_ijtag_tdr_driver #(.TDR_LEN(1)) dut1 (
        .ijtag_tck(ijtag_tck), .ijtag_reset(ijtag_reset),
        .req_valid(req_valid1), .req_ready(req_ready1), .req_wdata(req_wdata1),
        .rsp_valid(rsp_valid1), .rsp_rdata(rsp_rdata1), .busy(busy1),
        .ijtag_sel(sel1), .ijtag_ce(ce1), .ijtag_se(se1), .ijtag_ue(ue1),
        .ijtag_si(si1), .ijtag_so(so1)
    );

    always @(posedge ijtag_tck or negedge ijtag_reset) begin
        if (!ijtag_reset)    sr1 <= 1'b0;
        else if (sel1 & ce1) sr1 <= upd1;
        else if (sel1 & se1) sr1 <= si1;
    end
    always @(negedge ijtag_tck or negedge ijtag_reset) begin
        if (!ijtag_reset) begin
            so1  <= 1'b0;
            upd1 <= 1'b0;
        end else begin
            so1 <= sr1;
            if (sel1 & ue1) upd1 <= sr1;
        end
    end

    // ---------------- protocol checker (both drivers, every cycle)
    int se_cnt2 = 0;
    int se_cnt1 = 0;
    always @(negedge ijtag_tck) begin
        if (ijtag_reset) begin
            chk("onehot_en2", 32'($onehot0({ce2, se2, ue2})), 32'd1);
            chk("en_wo_sel2", 32'((ce2 | se2 | ue2) & ~sel2), 32'd0);
            chk("onehot_en1", 32'($onehot0({ce1, se1, ue1})), 32'd1);
            chk("en_wo_sel1", 32'((ce1 | se1 | ue1) & ~sel1), 32'd0);
            if (se2) se_cnt2++;
            if (se1) se_cnt1++;
            if (rsp_valid2) begin chk("se_len2", 32'(se_cnt2), 32'd2); se_cnt2 = 0; end
            if (rsp_valid1) begin chk("se_len1", 32'(se_cnt1), 32'd1); se_cnt1 = 0; end
        end else begin
            se_cnt2 = 0;
            se_cnt1 = 0;
        end
    end

    // ---------------- access tasks
    task automatic access2(input logic [1:0] w, input logic [1:0] er,
                           input logic eb, input logic el);
        int n;
        @(negedge ijtag_tck);
        n = 0;
        while (!req_ready2 && n < 50) begin @(negedge ijtag_tck); n++; end
        chk("ready_wait2", 32'(req_ready2), 32'd1);
        req_valid2 = 1'b1;
        req_wdata2 = w;
        @(posedge ijtag_tck); #1;
        req_valid2 = 1'b0;
        n = 1;
        while (!rsp_valid2 && n < 20) begin @(posedge ijtag_tck); #1; n++; end
        chk("latency2", 32'(n), 32'd5);
        chk("rdata2", 32'(rsp_rdata2), 32'(er));
        chk("edt_bypass", 32'(edt_bypass), 32'(eb));
        chk("edt_lpse", 32'(edt_low_power_shift_en), 32'(el));
        chk("busy_done2", 32'({busy2, req_ready2}), 32'b10);
        @(posedge ijtag_tck); #1;
        chk("rsp_pulse2", 32'({rsp_valid2, req_ready2}), 32'b01);
        chk("rdata_hold2", 32'(rsp_rdata2), 32'(er));
    endtask

    task automatic access1(input logic w, input logic er);
        int n;
        @(negedge ijtag_tck);
        n = 0;
        while (!req_ready1 && n < 50) begin @(negedge ijtag_tck); n++; end
        chk("ready_wait1", 32'(req_ready1), 32'd1);
        req_valid1 = 1'b1;
        req_wdata1 = w;
        @(posedge ijtag_tck); #1;
        req_valid1 = 1'b0;
        n = 1;
        while (!rsp_valid1 && n < 20) begin @(posedge ijtag_tck); #1; n++; end
        chk("latency1", 32'(n), 32'd4);
        chk("rdata1", 32'(rsp_rdata1), 32'(er));
        chk("upd1", 32'(upd1), 32'(w));
    endtask

    typedef struct {
        logic [1:0] w;
        logic [1:0] r;
        logic       byp;
        logic       lpse;
    } vec_t;
    vec_t vt[5];

    initial begin
        int acc, rsp, last_acc, n;
        vt[0] = '{w: 2'b11, r: 2'b00, byp: 1'b1, lpse: 1'b1};
        vt[1] = '{w: 2'b10, r: 2'b11, byp: 1'b0, lpse: 1'b1};
        vt[2] = '{w: 2'b01, r: 2'b10, byp: 1'b1, lpse: 1'b0};
        vt[3] = '{w: 2'b00, r: 2'b01, byp: 1'b0, lpse: 1'b0};
        vt[4] = '{w: 2'b11, r: 2'b00, byp: 1'b1, lpse: 1'b1};

        // reset state
        repeat (2) @(negedge ijtag_tck);
        chk("rst_ready", 32'(req_ready2), 32'd1);
        chk("rst_busy", 32'(busy2), 32'd0);
        chk("rst_rsp", 32'(rsp_valid2), 32'd0);
        chk("rst_rdata", 32'(rsp_rdata2), 32'd0);
        chk("rst_ctl", 32'({sel2, ce2, se2, ue2, si2}), 32'd0);
        ijtag_reset = 1'b1;

        for (int i = 0; i < 5; i++) access2(vt[i].w, vt[i].r, vt[i].byp, vt[i].lpse);

        // req_valid held: one accept every 6 cycles, one rsp per accept
        @(negedge ijtag_tck);
        n = 0;
        while (!req_ready2 && n < 20) begin @(negedge ijtag_tck); n++; end
        req_valid2 = 1'b1;
        req_wdata2 = 2'b01;
        acc = 0; rsp = 0; last_acc = -6;
        for (int k = 0; k < 36; k++) begin
            if (req_ready2) begin
                acc++;
                chk("acc_spacing", 32'(k - last_acc), 32'd6);
                last_acc = k;
            end
            if (req_ready2 && busy2) chk("ready_busy", 32'd1, 32'd0);
            if (rsp_valid2) rsp++;
            if (k == 35) req_valid2 = 1'b0;
            @(negedge ijtag_tck);
        end
        chk("cont_acc", 32'(acc), 32'd6);
        chk("cont_rsp", 32'(rsp), 32'd6);

        // reset in the second SHIFT cycle aborts the access
        req_valid2 = 1'b1;
        req_wdata2 = 2'b11;
        @(posedge ijtag_tck); #1;
        req_valid2 = 1'b0;
        repeat (2) @(posedge ijtag_tck);
        #1;
        chk("pre_rst_se", 32'(se2), 32'd1);
        ijtag_reset = 1'b0;
        #1;
        chk("abort_ctl", 32'({sel2, ce2, se2, ue2, si2}), 32'd0);
        chk("abort_state", 32'({busy2, req_ready2, rsp_valid2}), 32'b010);
        chk("abort_rdata", 32'(rsp_rdata2), 32'd0);
        chk("abort_target", 32'(upd2), 32'd0);
        rsp = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge ijtag_tck);
            if (rsp_valid2) rsp++;
        end
        ijtag_reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge ijtag_tck);
            if (rsp_valid2) rsp++;
        end
        chk("abort_no_rsp", 32'(rsp), 32'd0);
        access2(2'b10, 2'b00, 1'b0, 1'b1);

        // TDR_LEN = 1 build
        access1(1'b1, 1'b0);
        access1(1'b0, 1'b1);

        repeat (3) @(negedge ijtag_tck);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout: got no finish, expected finish before 200000");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
